// File: rtl/layer_req_arbiter_if.sv
// Request/command bundle between the layer requesters,
// the layer_req_arbiter and the one-hot layer selector.
interface layer_req_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_layer;
    logic [2:0]        layer_in;
    logic [2:0]        cmd_state;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   err;
    logic              busy;

    modport master (
        output req, req_layer, layer_in,
        input  cmd_state, ack, err, busy
    );

    modport slave (
        input  req, req_layer, layer_in,
        output cmd_state, ack, err, busy
    );
endinterface

// File: rtl/layer_req_arbiter.sv
// Round-robin arbiter sharing the one-hot layer selector.
// Optional AUTO_CYCLE_EN: idle-time automatic layer advance.
module layer_req_arbiter #(
    parameter int NREQ        = 3,
    parameter int TIMEOUT     = 15,
    parameter int AUTO_PERIOD = 50000000
) (
    input  logic               clk,
    input  logic               resetn,
    layer_req_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [2:0]      tgt_q, tgt_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            busy_q, busy_d;

    logic [2*NREQ-1:0] req_rot;
    logic [IW:0]       sum;
    logic              found;
    logic [IW-1:0]     sel;
    logic [2:0]        sel_lay;
    logic [NREQ-1:0]   sel_oh;
    logic [NREQ-1:0]   win_oh;

    logic              auto_fire;
    logic [2:0]        auto_tgt;
    logic              is_auto;

    function automatic logic is_oh(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    assign req_rot = {bus.req, bus.req} >> ptr_q;
    assign sel_oh  = ONE << sel;
    assign win_oh  = ONE << win_q;

    // Round-robin pick: first pending request at or above ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sum     = '0;
        sel_lay = 3'b000;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (IW+1)'(k);
                if (sum >= (IW+1)'(NREQ)) begin
                    sum = sum - (IW+1)'(NREQ);
                end
                sel = sum[IW-1:0];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (sel == IW'(k)) begin
                sel_lay = bus.req_layer[3*k +: 3];
            end
        end
    end

`ifdef AUTO_CYCLE_EN
    localparam logic [31:0] IDLE_LAST = 32'(AUTO_PERIOD - 1);

    logic [31:0] idle_q, idle_d;
    logic        auto_q, auto_d;

    assign auto_fire = (state_q == IDLE) && (bus.req == '0) &&
                       (idle_q == IDLE_LAST);
    assign is_auto   = auto_q;

    // Idle counter and internal-transaction flag for the auto advance.
    always_comb begin
        auto_tgt = 3'b001;
        unique case (bus.layer_in)
            3'b001:  auto_tgt = 3'b010;
            3'b010:  auto_tgt = 3'b100;
            3'b100:  auto_tgt = 3'b001;
            default: auto_tgt = 3'b001;
        endcase
        idle_d = '0;
        if (state_q == IDLE && bus.req == '0 && !auto_fire) begin
            idle_d = idle_q + 32'd1;
        end
        auto_d = auto_q;
        if (auto_fire) begin
            auto_d = 1'b1;
        end else if (state_q == RESP) begin
            auto_d = 1'b0;
        end
    end
`else
    assign auto_fire = 1'b0;
    assign auto_tgt  = 3'b000;
    assign is_auto   = 1'b0;
`endif

    // Transaction FSM next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        cmd_d   = 3'b000;
        ack_d   = '0;
        err_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d = sel;
                    tgt_d = sel_lay;
                    ptr_d = (sel == LAST_IDX) ? '0 : sel + IW'(1);
                    if (!is_oh(sel_lay)) begin
                        state_d = RESP;
                        err_d   = sel_oh;
                    end else if (sel_lay == bus.layer_in) begin
                        state_d = RESP;
                        ack_d   = sel_oh;
                    end else begin
                        state_d = ISSUE;
                        cmd_d   = sel_lay;
                    end
                end else if (auto_fire) begin
                    tgt_d   = auto_tgt;
                    state_d = ISSUE;
                    cmd_d   = auto_tgt;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.layer_in == tgt_q) begin
                    state_d = RESP;
                    ack_d   = is_auto ? '0 : win_oh;
                end else if (cnt_q == TO_LAST) begin
                    state_d = RESP;
                    err_d   = is_auto ? '0 : win_oh;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            tgt_q   <= 3'b000;
            cmd_q   <= 3'b000;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
`ifdef AUTO_CYCLE_EN
            idle_q  <= '0;
            auto_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            tgt_q   <= tgt_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef AUTO_CYCLE_EN
            idle_q  <= idle_d;
            auto_q  <= auto_d;
`endif
        end
    end

    assign bus.cmd_state = cmd_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_layer_req_arbiter.sv
// Directed bench for layer_req_arbiter with a selector model
// and a scoreboard of expected ack/err/cmd events.
module tb_layer_req_arbiter;
    localparam int NREQ = 3;

    typedef struct {
        int              t0;
        int              lat;
        logic [2:0]      cmd;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } cmd_ev_t;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
    } rsp_ev_t;

    logic       clk;
    logic       resetn;
    logic [2:0] sel_q;
    logic [2:0] sel_val;
    bit         sel_load;
    bit         sel_freeze;
    int         cyc;
    int         checks;
    int         errors;

    exp_t    exp_q[$];
    cmd_ev_t cmd_log[$];
    rsp_ev_t rsp_log[$];

    layer_req_arbiter_if #(.NREQ(NREQ)) bus ();

    layer_req_arbiter #(
        .NREQ       (NREQ),
        .TIMEOUT    (15),
        .AUTO_PERIOD(8)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    assign bus.layer_in = sel_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Layer selector model: adopts any non-zero command at the next edge.
    always @(posedge clk) begin
        if (sel_load) begin
            sel_q <= sel_val;
        end else if (!sel_freeze && bus.cmd_state != 3'b000) begin
            sel_q <= bus.cmd_state;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.cmd_state != 3'b000) begin
            cmd_log.push_back('{cyc, bus.cmd_state});
        end
        if ((bus.ack | bus.err) != '0) begin
            rsp_log.push_back('{cyc, bus.ack, bus.err});
            chk("single_pulse", 32'($onehot({bus.ack, bus.err})), 32'd1);
        end
    end

    task automatic set_layer(input int i, input logic [2:0] v);
        bus.req_layer[3*i +: 3] = v;
    endtask

    task automatic push_exp(input int t0, input int lat, input logic [2:0] cmd,
                            input logic [NREQ-1:0] a, input logic [NREQ-1:0] e);
        exp_q.push_back('{t0, lat, cmd, a, e});
    endtask

    task automatic await_rsp(input string tag, output int rc);
        exp_t    x;
        rsp_ev_t r;
        bit      got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            got = (rsp_log.size() != 0);
        end
        rc = cyc;
        x  = exp_q.pop_front();
        chk({tag, "_rsp"}, 32'(rsp_log.size()), 32'd1);
        if (got) begin
            r  = rsp_log.pop_front();
            rc = r.cyc;
            chk({tag, "_ack"}, 32'(r.ack), 32'(x.ack));
            chk({tag, "_err"}, 32'(r.err), 32'(x.err));
            chk({tag, "_lat"}, 32'(r.cyc - x.t0), 32'(x.lat));
        end
        if (x.cmd == 3'b000) begin
            chk({tag, "_nocmd"}, 32'(cmd_log.size()), 32'd0);
        end else begin
            chk({tag, "_ncmd"}, 32'(cmd_log.size()), 32'd1);
            if (cmd_log.size() != 0) begin
                chk({tag, "_cmd"}, 32'(cmd_log[0].val), 32'(x.cmd));
                chk({tag, "_cmdcyc"}, 32'(cmd_log[0].cyc - x.t0), 32'd1);
            end
        end
        cmd_log.delete();
    endtask

    task automatic do_reset(input logic [2:0] lay);
        @(negedge clk);
        #1;
        bus.req  = '0;
        sel_load = 1'b1;
        sel_val  = lay;
        resetn   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        sel_load = 1'b0;
        resetn   = 1'b1;
    endtask

    initial begin
        int c;
        int rc;
        int bad;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        resetn        = 1'b1;
        bus.req       = '0;
        bus.req_layer = '0;
        sel_load      = 1'b1;
        sel_val       = 3'b001;
        sel_freeze    = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_cmd", 32'(bus.cmd_state), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

`ifdef AUTO_CYCLE_EN
        do_reset(3'b100);
        c = cyc;
        for (int i = 0; i < 20 && cmd_log.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("auto_seen", 32'(cmd_log.size()), 32'd1);
        if (cmd_log.size() != 0) begin
            chk("auto_cyc", 32'(cmd_log[0].cyc - c), 32'd8);
            chk("auto_val", 32'(cmd_log[0].val), 32'b001);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("auto_noresp", 32'(rsp_log.size()), 32'd0);
        chk("auto_onecmd", 32'(cmd_log.size()), 32'd1);
        chk("auto_idle_busy", 32'(bus.busy), 32'd0);
        cmd_log.delete();
        c = cyc;
        repeat (5) @(negedge clk);
        #1;
        set_layer(2, 3'b001);
        bus.req = 3'b100;
        push_exp(c + 5, 1, 3'b000, 3'b100, 3'b000);
        await_rsp("auto_req", rc);
        bus.req = '0;
        for (int i = 0; i < 20 && cmd_log.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("auto2_seen", 32'(cmd_log.size()), 32'd1);
        if (cmd_log.size() != 0) begin
            chk("auto2_cyc", 32'(cmd_log[0].cyc - c), 32'd15);
            chk("auto2_val", 32'(cmd_log[0].val), 32'b010);
        end
        cmd_log.delete();
`else
        repeat (3) @(negedge clk);
        #1;
        sel_load = 1'b0;
        resetn   = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (bus.cmd_state != 3'b000 || bus.busy ||
                bus.ack != '0 || bus.err != '0) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);
        chk("idle_nocmd", 32'(cmd_log.size()), 32'd0);
        chk("idle_norsp", 32'(rsp_log.size()), 32'd0);

        @(negedge clk);
        #1;
        c = cyc;
        set_layer(0, 3'b010);
        bus.req = 3'b001;
        push_exp(c, 3, 3'b010, 3'b001, 3'b000);
        await_rsp("single", rc);
        bus.req = '0;
        @(negedge clk);
        #1;
        chk("single_busy_t4", 32'(bus.busy), 32'd0);

        do_reset(3'b010);
        @(negedge clk);
        #1;
        c = cyc;
        set_layer(0, 3'b100);
        set_layer(1, 3'b010);
        set_layer(2, 3'b001);
        bus.req = 3'b111;
        push_exp(c, 3, 3'b100, 3'b001, 3'b000);
        await_rsp("rr_a0", rc);
        bus.req[0] = 1'b0;
        push_exp(rc + 1, 3, 3'b010, 3'b010, 3'b000);
        await_rsp("rr_a1", rc);
        bus.req[1] = 1'b0;
        push_exp(rc + 1, 3, 3'b001, 3'b100, 3'b000);
        await_rsp("rr_a2", rc);
        bus.req[2] = 1'b0;

        @(negedge clk);
        #1;
        c = cyc;
        set_layer(0, 3'b010);
        bus.req = 3'b001;
        push_exp(c, 3, 3'b010, 3'b001, 3'b000);
        await_rsp("rr_prep", rc);
        bus.req = '0;

        @(negedge clk);
        #1;
        c = cyc;
        set_layer(1, 3'b100);
        set_layer(2, 3'b001);
        set_layer(0, 3'b010);
        bus.req = 3'b111;
        push_exp(c, 3, 3'b100, 3'b010, 3'b000);
        await_rsp("rr_b1", rc);
        bus.req[1] = 1'b0;
        push_exp(rc + 1, 3, 3'b001, 3'b100, 3'b000);
        await_rsp("rr_b2", rc);
        bus.req[2] = 1'b0;
        push_exp(rc + 1, 3, 3'b010, 3'b001, 3'b000);
        await_rsp("rr_b0", rc);
        bus.req[0] = 1'b0;

        @(negedge clk);
        #1;
        c = cyc;
        set_layer(1, 3'b011);
        bus.req = 3'b010;
        push_exp(c, 1, 3'b000, 3'b000, 3'b010);
        await_rsp("bad_011", rc);
        bus.req = '0;

        @(negedge clk);
        #1;
        c = cyc;
        set_layer(2, 3'b010);
        bus.req = 3'b100;
        push_exp(c, 1, 3'b000, 3'b100, 3'b000);
        await_rsp("same_layer", rc);
        bus.req = '0;

        @(negedge clk);
        #1;
        c = cyc;
        set_layer(0, 3'b000);
        bus.req = 3'b001;
        push_exp(c, 1, 3'b000, 3'b000, 3'b001);
        await_rsp("bad_000", rc);
        bus.req = '0;

        sel_freeze = 1'b1;
        @(negedge clk);
        #1;
        c = cyc;
        set_layer(1, 3'b100);
        bus.req = 3'b010;
        push_exp(c, 17, 3'b100, 3'b000, 3'b010);
        await_rsp("timeout", rc);
        bus.req = '0;

        @(negedge clk);
        #1;
        set_layer(2, 3'b100);
        bus.req = 3'b100;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_busy_wait", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_cmd", 32'(bus.cmd_state), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ack", 32'(bus.ack), 32'd0);
        chk("abort_err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        bus.req    = '0;
        resetn     = 1'b1;
        sel_freeze = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("abort_norsp", 32'(rsp_log.size()), 32'd0);
        chk("abort_onecmd", 32'(cmd_log.size()), 32'd1);
        cmd_log.delete();
`endif
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
